// File: rtl/pushbutton_event_sequencer.sv
// Pushbutton PIO event sequencer: services edge-capture interrupts, clears the
// captured bits and queues one timestamped event per button in a FWFT FIFO.
module pushbutton_event_sequencer #(
  parameter int         FIFO_DEPTH = 8,
  parameter int         TS_WIDTH   = 16,
  parameter logic [3:0] MASK_INIT  = 4'hF
) (
  input  logic                        clk,
  input  logic                        reset,
  output logic [1:0]                  pio_address,
  output logic                        pio_chipselect,
  output logic                        pio_write_n,
  output logic [31:0]                 pio_writedata,
  input  logic [31:0]                 pio_readdata,
  input  logic                        pio_irq,
  input  logic [3:0]                  mask_cfg,
  input  logic                        mask_update,
  output logic                        event_valid,
  input  logic                        event_ready,
  output logic [1:0]                  event_button,
  output logic [TS_WIDTH-1:0]         event_time,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {INIT, IDLE, RD_ADDR, RD_DATA, CLR, PUSH} state_t;

  typedef struct packed {
    logic [1:0]          button;
    logic [TS_WIDTH-1:0] ts;
  } evt_t;

  state_t              state;
  logic [3:0]          mask_reg;
  logic                mask_pend;
  logic [3:0]          mask_pend_val;
  logic [3:0]          pend;
  logic [TS_WIDTH-1:0] ts_cnt;
  logic [TS_WIDTH-1:0] ts_snap;

  evt_t                mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [AW:0]         count;

  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic [1:0]          push_btn;
  logic [3:0]          pend_next;
  logic [3:0]          rd_pend;
  logic                unused_rd;

  function automatic logic [1:0] lsb_idx(input logic [3:0] v);
    if (v[0])      lsb_idx = 2'd0;
    else if (v[1]) lsb_idx = 2'd1;
    else if (v[2]) lsb_idx = 2'd2;
    else           lsb_idx = 2'd3;
  endfunction

  assign unused_rd = ^pio_readdata[31:4];
  assign rd_pend   = pio_readdata[3:0] & mask_reg;

  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign push_btn  = lsb_idx(pend);
  assign pend_next = pend & ~(4'b0001 << push_btn);
  // A full FIFO refuses the push even when a pop frees a slot this cycle.
  assign push      = (state == PUSH) && !full && !reset;
  assign pop       = event_valid && event_ready;

  always_ff @(posedge clk) begin
    if (reset) ts_cnt <= '0;
    else       ts_cnt <= ts_cnt + TS_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= INIT;
      mask_reg      <= MASK_INIT;
      mask_pend     <= 1'b0;
      mask_pend_val <= 4'h0;
      pend          <= 4'h0;
      ts_snap       <= '0;
    end else begin
      // Mask requests outside IDLE are parked until the sequencer is free.
      if (mask_update && state != IDLE) begin
        mask_pend     <= 1'b1;
        mask_pend_val <= mask_cfg;
      end
      case (state)
        INIT: state <= IDLE;
        IDLE: begin
          if (mask_update) begin
            mask_reg  <= mask_cfg;
            mask_pend <= 1'b0;
            state     <= INIT;
          end else if (mask_pend) begin
            mask_reg  <= mask_pend_val;
            mask_pend <= 1'b0;
            state     <= INIT;
          end else if (pio_irq) begin
            state <= RD_ADDR;
          end
        end
        RD_ADDR: state <= RD_DATA;
        RD_DATA: begin
          pend    <= rd_pend;
          ts_snap <= ts_cnt;
          state   <= (rd_pend == 4'h0) ? IDLE : CLR;
        end
        CLR: state <= PUSH;
        PUSH: begin
          if (!full) begin
            pend <= pend_next;
            if (pend_next == 4'h0) state <= IDLE;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{button: push_btn, ts: ts_snap};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign event_valid  = !empty && !reset;
  assign event_button = event_valid ? mem[rd_ptr].button : 2'd0;
  assign event_time   = event_valid ? mem[rd_ptr].ts : '0;
  assign fifo_count   = count;
  assign busy         = reset || (state != IDLE);

  // Bus strobes decode straight from the state so the write lands in the state's own cycle.
  always_comb begin
    pio_address    = 2'd0;
    pio_chipselect = 1'b0;
    pio_write_n    = 1'b1;
    pio_writedata  = 32'h0;
    if (!reset) begin
      case (state)
        INIT: begin
          pio_address    = 2'd2;
          pio_chipselect = 1'b1;
          pio_write_n    = 1'b0;
          pio_writedata  = {28'h0, mask_reg};
        end
        RD_ADDR: begin
          pio_address    = 2'd3;
          pio_chipselect = 1'b1;
        end
        CLR: begin
          pio_address    = 2'd3;
          pio_chipselect = 1'b1;
          pio_write_n    = 1'b0;
          pio_writedata  = {28'h0, pend};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pushbutton_event_sequencer.sv
// Directed bench for pushbutton_event_sequencer with a small edge-capture PIO model.
module tb_pushbutton_event_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;
  logic [31:0] pio_readdata = 32'h0;
  logic        pio_irq;
  logic [3:0]  mask_cfg = 4'h0;
  logic        mask_update = 1'b0;
  logic        event_valid;
  logic        event_ready = 1'b0;
  logic [1:0]  event_button;
  logic [15:0] event_time;
  logic [3:0]  fifo_count;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  pushbutton_event_sequencer #(.FIFO_DEPTH(8), .TS_WIDTH(16), .MASK_INIT(4'hF)) dut (
    .clk(clk), .reset(reset),
    .pio_address(pio_address), .pio_chipselect(pio_chipselect),
    .pio_write_n(pio_write_n), .pio_writedata(pio_writedata),
    .pio_readdata(pio_readdata), .pio_irq(pio_irq),
    .mask_cfg(mask_cfg), .mask_update(mask_update),
    .event_valid(event_valid), .event_ready(event_ready),
    .event_button(event_button), .event_time(event_time),
    .fifo_count(fifo_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // PIO model: write-1-to-clear edge capture, irq mask, registered read data.
  logic [3:0] ec = 4'h0;
  logic [3:0] pmask = 4'h0;
  logic [3:0] edge_in = 4'h0;
  logic       irq_force = 1'b0;
  logic [3:0] pio_clr;
  assign pio_clr = (pio_chipselect && !pio_write_n && pio_address == 2'd3) ? pio_writedata[3:0] : 4'h0;
  assign pio_irq = (|(ec & pmask)) | irq_force;
  always @(posedge clk) begin
    if (pio_chipselect && !pio_write_n && pio_address == 2'd2) pmask <= pio_writedata[3:0];
    ec <= (ec & ~pio_clr) | edge_in;
    pio_readdata <= (pio_address == 2'd3) ? {28'h0, ec} : 32'h0;
  end

  // Reference cycle stamp, reset and advanced like the spec's free-running counter.
  logic [15:0] tb_ts = 16'h0;
  always @(posedge clk) tb_ts <= reset ? 16'h0 : tb_ts + 16'h1;

  int n_init_wr = 0;
  int n_clr_wr = 0;
  always @(negedge clk) begin
    if (pio_chipselect && !pio_write_n && pio_address == 2'd2) n_init_wr++;
    if (pio_chipselect && !pio_write_n && pio_address == 2'd3) n_clr_wr++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic trig(input int b, output logic [15:0] t);
    cyc();
    edge_in = 4'b0001 << b;
    cyc();
    edge_in = 4'h0;
    t = tb_ts + 16'd2;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 30; k++) begin
      cyc();
      if (!busy) break;
    end
  endtask

  task automatic test_reset();
    cyc();
    cyc();
    n_cmp++;
    if ({busy, event_valid, fifo_count} !== {1'b1, 1'b0, 4'd0}) begin
      n_bad++; $display("FAIL reset_status: got %b expected %b", {busy, event_valid, fifo_count}, 6'b100000);
    end
    n_cmp++;
    if ({pio_chipselect, pio_write_n, pio_address, pio_writedata} !== {1'b0, 1'b1, 2'd0, 32'h0}) begin
      n_bad++; $display("FAIL reset_bus_idle: got cs=%b wn=%b a=%0d d=%h", pio_chipselect, pio_write_n, pio_address, pio_writedata);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({pio_chipselect, pio_write_n, pio_address, pio_writedata} !== {1'b1, 1'b0, 2'd2, 32'h0000000F}) begin
      n_bad++; $display("FAIL init_write: got cs=%b wn=%b a=%0d d=%h expected 1 0 2 0000000f", pio_chipselect, pio_write_n, pio_address, pio_writedata);
    end
    cyc();
    n_cmp++;
    if ({busy, pio_chipselect, n_init_wr} !== {1'b0, 1'b0, 32'd1}) begin
      n_bad++; $display("FAIL init_done: got busy=%b cs=%b writes=%0d expected 0 0 1", busy, pio_chipselect, n_init_wr);
    end
  endtask

  task automatic test_basic();
    logic [15:0] t;
    trig(0, t);
    edge_in = 4'h0;
    t = tb_ts + 16'd2;
    cyc(); cyc();  // lowest-bit-only path would differ; redo with 0x5 below
    wait_idle();
    event_ready = 1'b1;
    cyc();
    event_ready = 1'b0;
    cyc();
    edge_in = 4'h5;
    cyc();
    edge_in = 4'h0;
    t = tb_ts + 16'd2;
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_idle_at_T: got busy=%b expected 0", busy); end
    cyc();
    n_cmp++;
    if ({pio_chipselect, pio_write_n, pio_address} !== {1'b1, 1'b1, 2'd3}) begin
      n_bad++; $display("FAIL basic_rd_addr: got cs=%b wn=%b a=%0d expected 1 1 3", pio_chipselect, pio_write_n, pio_address);
    end
    cyc();
    cyc();
    n_cmp++;
    if ({pio_chipselect, pio_write_n, pio_address, pio_writedata} !== {1'b1, 1'b0, 2'd3, 32'h5}) begin
      n_bad++; $display("FAIL basic_clr_write: got cs=%b wn=%b a=%0d d=%h expected 1 0 3 00000005", pio_chipselect, pio_write_n, pio_address, pio_writedata);
    end
    cyc();
    n_cmp++;
    if (event_valid !== 1'b0) begin n_bad++; $display("FAIL basic_valid_T4: got %b expected 0", event_valid); end
    cyc();
    n_cmp++;
    if ({event_valid, event_button, event_time, fifo_count} !== {1'b1, 2'd0, t, 4'd1}) begin
      n_bad++; $display("FAIL basic_first_event: got v=%b b=%0d t=%h n=%0d expected 1 0 %h 1", event_valid, event_button, event_time, fifo_count, t);
    end
    event_ready = 1'b1;
    cyc();
    n_cmp++;
    if ({event_valid, event_button, event_time, fifo_count, busy} !== {1'b1, 2'd2, t, 4'd1, 1'b0}) begin
      n_bad++; $display("FAIL basic_second_event: got v=%b b=%0d t=%h n=%0d busy=%b expected 1 2 %h 1 0", event_valid, event_button, event_time, fifo_count, busy, t);
    end
    cyc();
    event_ready = 1'b0;
    n_cmp++;
    if ({event_valid, event_button, event_time, fifo_count} !== {1'b0, 2'd0, 16'h0, 4'd0}) begin
      n_bad++; $display("FAIL basic_empty_zero: got v=%b b=%0d t=%h n=%0d expected all 0", event_valid, event_button, event_time, fifo_count);
    end
  endtask

  task automatic test_fifo_full();
    logic [1:0]  eb [10];
    logic [15:0] et [10];
    logic [15:0] tsp;
    int idx;
    for (int i = 0; i < 8; i++) begin
      trig(i % 4, et[i]);
      eb[i] = 2'(i % 4);
      wait_idle();
    end
    n_cmp++;
    if ({fifo_count, busy} !== {4'd8, 1'b0}) begin
      n_bad++; $display("FAIL full_fill: got n=%0d busy=%b expected 8 0", fifo_count, busy);
    end
    trig(0, et[8]);
    eb[8] = 2'd0;
    repeat (10) cyc();
    n_cmp++;
    if ({fifo_count, busy, event_valid, event_button, event_time} !== {4'd8, 1'b1, 1'b1, eb[0], et[0]}) begin
      n_bad++; $display("FAIL full_stall: got n=%0d busy=%b v=%b b=%0d t=%h expected 8 1 1 %0d %h", fifo_count, busy, event_valid, event_button, event_time, eb[0], et[0]);
    end
    cyc();
    edge_in = 4'h2;
    cyc();
    edge_in = 4'h0;
    eb[9] = 2'd1;
    repeat (3) cyc();
    tsp = tb_ts;
    et[9] = tsp + 16'd4;
    event_ready = 1'b1;
    cyc();
    event_ready = 1'b0;
    n_cmp++;
    if (fifo_count !== 4'd7) begin n_bad++; $display("FAIL full_after_pop: got %0d expected 7", fifo_count); end
    cyc();
    n_cmp++;
    if (fifo_count !== 4'd8) begin n_bad++; $display("FAIL full_ninth_in: got %0d expected 8", fifo_count); end
    repeat (8) cyc();
    n_cmp++;
    if ({fifo_count, busy} !== {4'd8, 1'b1}) begin
      n_bad++; $display("FAIL full_tenth_stall: got n=%0d busy=%b expected 8 1", fifo_count, busy);
    end
    idx = 1;
    event_ready = 1'b1;
    for (int k = 0; k < 60 && idx < 10; k++) begin
      if (event_valid) begin
        n_cmp++;
        if ({event_button, event_time} !== {eb[idx], et[idx]}) begin
          n_bad++; $display("FAIL full_order[%0d]: got b=%0d t=%h expected b=%0d t=%h", idx, event_button, event_time, eb[idx], et[idx]);
        end
        idx++;
      end
      cyc();
    end
    event_ready = 1'b0;
    n_cmp++;
    if ({idx, fifo_count, busy} !== {32'd10, 4'd0, 1'b0}) begin
      n_bad++; $display("FAIL full_drain: got idx=%0d n=%0d busy=%b expected 10 0 0", idx, fifo_count, busy);
    end
  endtask

  task automatic test_mask_update();
    logic [15:0] t;
    int nclr;
    trig(2, t);
    cyc();
    cyc();
    mask_update = 1'b1;
    mask_cfg = 4'h3;
    cyc();
    mask_update = 1'b0;
    n_cmp++;
    if ({pio_chipselect, pio_write_n, pio_address, pio_writedata} !== {1'b1, 1'b0, 2'd3, 32'h4}) begin
      n_bad++; $display("FAIL mask_clr_write: got cs=%b wn=%b a=%0d d=%h expected 1 0 3 00000004", pio_chipselect, pio_write_n, pio_address, pio_writedata);
    end
    cyc();
    cyc();
    n_cmp++;
    if ({event_valid, event_button, event_time} !== {1'b1, 2'd2, t}) begin
      n_bad++; $display("FAIL mask_event: got v=%b b=%0d t=%h expected 1 2 %h", event_valid, event_button, event_time, t);
    end
    cyc();
    n_cmp++;
    if ({pio_chipselect, pio_write_n, pio_address, pio_writedata} !== {1'b1, 1'b0, 2'd2, 32'h3}) begin
      n_bad++; $display("FAIL mask_init_write: got cs=%b wn=%b a=%0d d=%h expected 1 0 2 00000003", pio_chipselect, pio_write_n, pio_address, pio_writedata);
    end
    event_ready = 1'b1;
    cyc();
    event_ready = 1'b0;
    nclr = n_clr_wr;
    edge_in = 4'hC;
    cyc();
    edge_in = 4'h0;
    irq_force = 1'b1;
    cyc();
    cyc();
    cyc();
    irq_force = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL spurious_return: got busy=%b expected 0", busy); end
    repeat (4) cyc();
    n_cmp++;
    if ({n_clr_wr, fifo_count, event_valid} !== {nclr, 4'd0, 1'b0}) begin
      n_bad++; $display("FAIL spurious_no_action: got clr_writes=%0d n=%0d v=%b expected %0d 0 0", n_clr_wr, fifo_count, event_valid, nclr);
    end
    mask_cfg = 4'hF;
    mask_update = 1'b1;
    cyc();
    mask_update = 1'b0;
    n_cmp++;
    if ({pio_chipselect, pio_write_n, pio_address, pio_writedata} !== {1'b1, 1'b0, 2'd2, 32'hF}) begin
      n_bad++; $display("FAIL mask_restore: got cs=%b wn=%b a=%0d d=%h expected 1 0 2 0000000f", pio_chipselect, pio_write_n, pio_address, pio_writedata);
    end
    cyc();
    t = tb_ts + 16'd2;
    wait_idle();
    n_cmp++;
    if ({fifo_count, event_button, event_time} !== {4'd2, 2'd2, t}) begin
      n_bad++; $display("FAIL mask_pass_c_first: got n=%0d b=%0d t=%h expected 2 2 %h", fifo_count, event_button, event_time, t);
    end
    event_ready = 1'b1;
    cyc();
    n_cmp++;
    if ({event_button, event_time} !== {2'd3, t}) begin
      n_bad++; $display("FAIL mask_pass_c_second: got b=%0d t=%h expected 3 %h", event_button, event_time, t);
    end
    cyc();
    event_ready = 1'b0;
  endtask

  task automatic test_simul_wrap();
    logic [15:0] ft [4];
    int idx;
    for (int i = 0; i < 4; i++) begin
      trig(i, ft[i]);
      wait_idle();
    end
    for (int k = 0; k < 70000 && tb_ts != 16'hFFFD; k++) cyc();
    n_cmp++;
    if (tb_ts !== 16'hFFFD) begin n_bad++; $display("FAIL wrap_wait_timeout: got %h expected fffd", tb_ts); end
    edge_in = 4'h1;
    cyc();
    edge_in = 4'h0;
    repeat (4) cyc();
    n_cmp++;
    if ({fifo_count, event_button, event_time} !== {4'd4, 2'd0, ft[0]}) begin
      n_bad++; $display("FAIL simul_before: got n=%0d b=%0d t=%h expected 4 0 %h", fifo_count, event_button, event_time, ft[0]);
    end
    event_ready = 1'b1;
    cyc();
    event_ready = 1'b0;
    n_cmp++;
    if ({fifo_count, event_button, event_time} !== {4'd4, 2'd1, ft[1]}) begin
      n_bad++; $display("FAIL simul_count_hold: got n=%0d b=%0d t=%h expected 4 1 %h", fifo_count, event_button, event_time, ft[1]);
    end
    idx = 1;
    event_ready = 1'b1;
    for (int k = 0; k < 20 && idx < 5; k++) begin
      if (event_valid) begin
        n_cmp++;
        if (idx < 4) begin
          if ({event_button, event_time} !== {2'(idx), ft[idx]}) begin
            n_bad++; $display("FAIL simul_order[%0d]: got b=%0d t=%h expected %0d %h", idx, event_button, event_time, idx, ft[idx]);
          end
        end else if ({event_button, event_time} !== {2'd0, 16'h0000}) begin
          n_bad++; $display("FAIL wrap_stamp: got b=%0d t=%h expected 0 0000", event_button, event_time);
        end
        idx++;
      end
      cyc();
    end
    event_ready = 1'b0;
    n_cmp++;
    if ({idx, fifo_count} !== {32'd5, 4'd0}) begin
      n_bad++; $display("FAIL simul_drain: got idx=%0d n=%0d expected 5 0", idx, fifo_count);
    end
  endtask

  task automatic test_reset_stall();
    logic [15:0] t;
    for (int i = 0; i < 8; i++) begin
      trig(i % 4, t);
      wait_idle();
    end
    trig(1, t);
    repeat (8) cyc();
    n_cmp++;
    if ({fifo_count, busy} !== {4'd8, 1'b1}) begin
      n_bad++; $display("FAIL rst_pre_stall: got n=%0d busy=%b expected 8 1", fifo_count, busy);
    end
    reset = 1'b1;
    cyc();
    n_cmp++;
    if ({busy, event_valid, fifo_count, event_button, event_time} !== {1'b1, 1'b0, 4'd0, 2'd0, 16'h0}) begin
      n_bad++; $display("FAIL rst_stall_clear: got busy=%b v=%b n=%0d b=%0d t=%h expected 1 0 0 0 0", busy, event_valid, fifo_count, event_button, event_time);
    end
    n_cmp++;
    if ({pio_chipselect, pio_write_n, pio_address, pio_writedata} !== {1'b0, 1'b1, 2'd0, 32'h0}) begin
      n_bad++; $display("FAIL rst_stall_bus: got cs=%b wn=%b a=%0d d=%h expected idle", pio_chipselect, pio_write_n, pio_address, pio_writedata);
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({pio_chipselect, pio_write_n, pio_address, pio_writedata} !== {1'b1, 1'b0, 2'd2, 32'hF}) begin
      n_bad++; $display("FAIL rst_stall_init: got cs=%b wn=%b a=%0d d=%h expected 1 0 2 0000000f", pio_chipselect, pio_write_n, pio_address, pio_writedata);
    end
    cyc();
    n_cmp++;
    if ({busy, fifo_count, event_valid} !== {1'b0, 4'd0, 1'b0}) begin
      n_bad++; $display("FAIL rst_stall_idle: got busy=%b n=%0d v=%b expected 0 0 0", busy, fifo_count, event_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fifo_full();
    test_mask_update();
    test_simul_wrap();
    test_reset_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pushbutton_event_sequencer.md
PUSHBUTTON_EVENT_SEQUENCER -- requirements
Module: pushbutton_event_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8: event FIFO entries; power of two, at least 2.
REQ-002 SHALL have parameter TS_WIDTH, default 16: timestamp width.
REQ-003 SHALL have parameter MASK_INIT, default 4'hF: irq_mask value written after reset.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 pio_address  out  2  PIO register address.
REQ-007 pio_chipselect  out  1  PIO select.
REQ-008 pio_write_n  out  1  PIO write strobe, active low.
REQ-009 pio_writedata  out  32  PIO write data.
REQ-010 pio_readdata  in  32  PIO read data; registered, valid the cycle after the address is presented.
REQ-011 pio_irq  in  1  PIO interrupt (masked edge_capture nonzero).
REQ-012 mask_cfg  in  4  new irq_mask value.
REQ-013 mask_update  in  1  one-cycle request to rewrite irq_mask with mask_cfg.
REQ-014 event_valid  out  1  FIFO head valid.
REQ-015 event_ready  in  1  consumer accept; a pop occurs when event_valid && event_ready.
REQ-016 event_button  out  2  button index of the head event.
REQ-017 event_time  out  TS_WIDTH  timestamp of the head event.
REQ-018 fifo_count  out  log2(FIFO_DEPTH)+1  current occupancy.
REQ-019 busy  out  1  high whenever state is not IDLE.

Function
REQ-020 ts_cnt SHALL be a TS_WIDTH free-running counter, incrementing every cycle and wrapping to 0 after its maximum.
REQ-021 States SHALL be INIT, IDLE, RD_ADDR, RD_DATA, CLR, PUSH, with one state per cycle except where noted.
REQ-022 INIT: address=2, chipselect=1, write_n=0, writedata={28'b0,mask_reg}; next state IDLE.
REQ-023 IDLE: mask_update=1 loads mask_reg from mask_cfg and goes to INIT; else pio_irq=1 goes to RD_ADDR; else stays in IDLE; mask_update takes priority over pio_irq.
REQ-024 mask_update asserted outside IDLE SHALL be latched as pending and serviced on the next IDLE cycle; mask_cfg is sampled when the request is accepted.
REQ-025 RD_ADDR: address=3, chipselect=1, write_n=1; next state RD_DATA.
REQ-026 RD_DATA: capture pend = pio_readdata[3:0] & mask_reg and ts_snap = ts_cnt; if pend==0, go to IDLE with no write (spurious); else go to CLR.
REQ-027 CLR: address=3, chipselect=1, write_n=0, writedata={28'b0,pend}; clears only the captured bits; next state PUSH.
REQ-028 PUSH: if the FIFO is not full, push {lowest set bit index of pend, ts_snap} and clear that bit in pend.
REQ-029 PUSH with the FIFO full SHALL stall with no push and no loss.
REQ-030 PUSH SHALL exit to IDLE in the cycle its last set bit is pushed.
REQ-031 No push SHALL be accepted while full, even if a pop occurs in the same cycle.
REQ-032 Bus idle values, in every state without a strobe: chipselect=0, write_n=1, address=0, writedata=0.
REQ-033 FIFO SHALL be a first-word-fall-through circular buffer with wrapping pointers.
REQ-034 Simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-035 Pop on empty SHALL be ignored.
REQ-036 event_button/event_time SHALL hold the head entry while event_valid=1 and be 0 when the FIFO is empty.
REQ-037 Latency: pio_irq=1 in IDLE at cycle T -> RD_ADDR T+1, RD_DATA T+2, CLR T+3, first push T+4, event_valid=1 at T+5.
REQ-038 Edges arriving during the sequence SHALL remain in PIO edge_capture, re-raise pio_irq, and be serviced in a later pass.

Reset
REQ-039 reset=1 SHALL, on the next clock edge and from any state including mid-PUSH or stall, force state INIT.
REQ-040 On reset, mask_reg SHALL be MASK_INIT; ts_cnt, pend, ts_snap, FIFO pointers and fifo_count SHALL be 0; pending mask request SHALL be cleared.
REQ-041 During reset, event_valid=0, busy=1 and bus outputs SHALL take idle values.
REQ-042 The first cycle after reset release SHALL perform the INIT write of MASK_INIT.

Verification
REQ-043 Reset release -> one write: address 2, writedata 0x0000000F, then busy=0.
REQ-044 pio_irq with readdata 0x5 -> read address 3; write address 3, data 0x5; events (0,ts) then (2,ts) with identical ts; event_valid at T+5.
REQ-045 FIFO_DEPTH=8, event_ready=0, 10 single-bit irq passes -> fifo_count=8 and PUSH stalls; one pop -> 9th event enters; order preserved.
REQ-046 mask_update in RD_DATA with mask_cfg=0x3 -> after sequence, INIT write data 0x3; later readdata 0xC -> no CLR write, no events.
REQ-047 reset during PUSH stall with FIFO full -> fifo_count=0, event_valid=0, next cycle INIT write of 0xF.
REQ-048 Simultaneous push and pop at fifo_count=4 -> count stays 4; ts_cnt wrap from 0xFFFF to 0x0000 is stamped correctly.
